// File: rtl/byte_stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : byte_stream_fifo_pkg
// Brief   : Shared sizing constants for the register-write stage and its FIFO.
// Revision: 1.0
// ============================================================================
package byte_stream_fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 4;

    // Pointer index width for a power-of-two depth.
    function automatic int ptr_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_stream_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : byte_stream_fifo_ptr_ctrl
// Brief   : Wrap-bit read/write pointers, occupancy and sticky overflow flag.
// Revision: 1.0
// ============================================================================
module byte_stream_fifo_ptr_ctrl #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          push,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] wr_idx,
    output logic [AW-1:0] rd_idx,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_overflow;
    logic        w_pop;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    // Clear wins over any transfer in the same cycle, including the storage write.
    assign push   = in_valid && !full && !clear;
    assign w_pop  = out_ready && !empty && !clear;

    assign wr_idx   = r_wr_ptr[AW-1:0];
    assign rd_idx   = r_rd_ptr[AW-1:0];
    assign count    = r_wr_ptr - r_rd_ptr;
    assign overflow = r_overflow;

    task automatic do_push();
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
    endtask

    task automatic do_pop();
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
    endtask

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (push) begin
                do_push();
            end
            if (w_pop) begin
                do_pop();
            end
            if (in_valid && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/byte_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module  : byte_stream_fifo
// Brief   : FWFT byte FIFO behind a no-backpressure producer; drops when full.
// Revision: 1.0
// ============================================================================
module byte_stream_fifo
    import byte_stream_fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [ptr_idx_w(DEPTH):0]  count,
    output logic                       overflow
);

    localparam int AW = ptr_idx_w(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;

    byte_stream_fifo_ptr_ctrl #(
        .AW (AW)
    ) u_ptr_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .push      (w_push),
        .full      (w_full),
        .empty     (w_empty),
        .wr_idx    (w_wr_idx),
        .rd_idx    (w_rd_idx),
        .count     (count),
        .overflow  (overflow)
    );

    task automatic do_store(input logic [AW-1:0] idx, input logic [DATA_W-1:0] data);
        r_mem[idx] <= data;
    endtask

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            do_store(w_wr_idx, in_data);
        end
    end

    // Both flags come from registered pointers, so no input reaches them combinationally.
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = r_mem[w_rd_idx];

endmodule
`default_nettype wire

// File: tb/tb_byte_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_byte_stream_fifo
// Brief   : Directed and random stimulus against a queue-based FIFO model.
// Revision: 1.0
// ============================================================================
module tb_byte_stream_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic       m_ovf;

    byte_stream_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
    endtask

    // Model of one clock edge: fullness is judged before this cycle's pop.
    task automatic model_edge(input logic iv, input logic [7:0] id, input logic ordy, input logic clr);
        bit was_full;
        if (clr) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            if (ordy && q.size() != 0) void'(q.pop_front());
            if (iv) begin
                if (was_full) m_ovf = 1'b1;
                else          q.push_back(id);
            end
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic clr);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        model_edge(iv, id, ordy, clr);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        q.delete(); m_ovf = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
        chk("reset_out_data", 32'(out_data), 32'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("idle_out_data", 32'(out_data), 32'h00);

        // FWFT single byte
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("fwft_data", 32'(out_data), 32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill and overflow, then drain in order
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_overflow", 32'(overflow), 32'h1);
        chk("fill_head", 32'(out_data), 32'h01);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_overflow_sticky", 32'(overflow), 32'h1);

        // Simultaneous push and pop across pointer wrap
        step(1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
        chk("pushpop_count", 32'(count), 32'd2);

        // Clear with traffic: reach count=3, then clear
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h30, 1'b0, 1'b0);
        step(1'b1, 8'h31, 1'b0, 1'b0);
        chk("pre_clear_count", 32'(count), 32'd3);
        step(1'b1, 8'h77, 1'b1, 1'b1);
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_overflow", 32'(overflow), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic with occasional clear
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
        end

        // Async reset mid-stream with count=3
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd3);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete(); m_ovf = 1'b0;
        #1;
        check_all();
        chk("async_reset_out_data", 32'(out_data), 32'h00);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_reset_head", 32'(out_data), 32'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
